// File: rtl/systolic_row_drain.sv
`default_nettype none
// ============================================================================
// Module   : systolic_row_drain
// Purpose  : Output collector behind the systolic multiply array. Captures one
//            result row per cycle into a small first-word-fall-through FIFO,
//            tags each row with its index in the tile and a last flag, and
//            hands rows to the memory writer over valid/ready. The array
//            cannot stall, so rows arriving to a full FIFO are dropped and a
//            sticky overflow flag is raised.
// Ports    : clk, srst (sync, active-high)
//            start            - one-cycle pulse opening a tile
//            in_valid/in_row  - result row from the array (word j at j*DW)
//            modulus          - reduction modulus (MOD_REDUCE_EN builds only)
//            out_valid/out_ready/out_row/out_row_idx/out_last - head row
//            busy, done, overflow - status
// Config   : MOD_REDUCE_EN - when defined, each word w is stored as
//            (w >= modulus) ? w - modulus : w.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_row_drain #(
    parameter int ARRAY_ROWS    = 10,
    parameter int ARRAY_COLUMNS = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic                                start,
    input  logic                                in_valid,
    input  logic [ARRAY_COLUMNS*DATA_WIDTH-1:0] in_row,
    input  logic [DATA_WIDTH-1:0]               modulus,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ARRAY_COLUMNS*DATA_WIDTH-1:0] out_row,
    output logic [$clog2(ARRAY_ROWS)-1:0]       out_row_idx,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow
);

    localparam int c_ROW_W = ARRAY_COLUMNS * DATA_WIDTH;
    localparam int c_IDX_W = $clog2(ARRAY_ROWS);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(ARRAY_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_in_count;
    logic                 r_overflow;
    logic                 r_done;

    // Pointers carry one extra wrap bit: equal => empty, MSB differs with
    // equal low bits => full.
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic [c_ROW_W-1:0]   r_mem_row [FIFO_DEPTH];
    logic [c_IDX_W-1:0]   r_mem_idx [FIFO_DEPTH];

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_drop;
    logic                 w_start_tile;
    logic                 w_finish;
    logic                 w_head_last;
    logic [c_ROW_W-1:0]   w_row_wr;
    logic [c_ROW_W-1:0]   w_head_row;
    logic [c_IDX_W-1:0]   w_head_idx;

    // ------------------------------------------------------------------
    // Write-path word conditioning
    // ------------------------------------------------------------------
`ifdef MOD_REDUCE_EN
    for (genvar j = 0; j < ARRAY_COLUMNS; j++) begin : g_mod_reduce
        logic [DATA_WIDTH-1:0] w_word;
        assign w_word = in_row[j*DATA_WIDTH +: DATA_WIDTH];
        assign w_row_wr[j*DATA_WIDTH +: DATA_WIDTH] =
            (w_word >= modulus) ? (w_word - modulus) : w_word;
    end
`else
    logic w_unused_modulus;
    assign w_unused_modulus = ^modulus;
    assign w_row_wr         = in_row;
`endif

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_head_row  = r_mem_row[r_rd_ptr[c_AW-1:0]];
    assign w_head_idx  = r_mem_idx[r_rd_ptr[c_AW-1:0]];
    assign w_head_last = (w_head_idx == c_LAST_IDX);

    assign out_valid   = ~w_empty;
    assign w_pop       = out_valid & out_ready;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en     = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;

    assign out_row     = out_valid ? w_head_row : '0;
    assign out_row_idx = out_valid ? w_head_idx : '0;
    assign out_last    = out_valid & w_head_last;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign overflow    = r_overflow;

    // ------------------------------------------------------------------
    // Tile sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_start_tile = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_COLLECT;
                    w_start_tile = 1'b1;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    w_push = 1'b1;
                    if (r_in_count == c_LAST_IDX) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // If the last row was dropped this never fires; only srst exits.
                if (w_pop && w_head_last) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, flags and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_in_count <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_done <= w_finish;
            if (w_start_tile) begin
                r_in_count <= '0;
                r_overflow <= 1'b0;
            end else begin
                // Dropped rows still count so the tile always terminates.
                if (w_push) begin
                    r_in_count <= r_in_count + 1'b1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_row[r_wr_ptr[c_AW-1:0]] <= w_row_wr;
            r_mem_idx[r_wr_ptr[c_AW-1:0]] <= r_in_count;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_row_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_row_drain
// Purpose  : Self-checking bench for systolic_row_drain. A reference model
//            predicts FIFO contents into a scoreboard queue as rows are driven
//            and compares every output cycle; a scenario table drives whole
//            tiles, and hand-written sequences cover reset mid-tile and the
//            optional modular reduction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_row_drain;

    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int ROW_W = COLS * DW;
    localparam int IDX_W = $clog2(ROWS);

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_DRAIN   = 2;

    logic             clk;
    logic             srst;
    logic             start;
    logic             in_valid;
    logic [ROW_W-1:0] in_row;
    logic [DW-1:0]    modulus;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_row;
    logic [IDX_W-1:0] out_row_idx;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             overflow;

    systolic_row_drain #(
        .ARRAY_ROWS   (ROWS),
        .ARRAY_COLUMNS(COLS),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .start      (start),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .modulus    (modulus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_row_idx(out_row_idx),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ROW_W-1:0] row;
        int               idx;
    } exp_t;

    typedef struct {
        int ready_low_rows;   // out_ready held low until this row index
        bit idle_valid;       // drive in_valid while IDLE first
        bit second_start;     // pulse start again during COLLECT
        int exp_rows;         // rows delivered
        int exp_done;         // done pulses
        bit exp_ovf;          // overflow at end
    } vec_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   n_done = 0;
    bit   mon_en = 1'b1;

    int   m_st = M_IDLE;
    int   m_cnt_in = 0;
    bit   m_ovf = 1'b0;
    bit   m_done = 1'b0;

    task automatic check(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [ROW_W-1:0] make_row(input int r);
        logic [ROW_W-1:0] v;
        for (int j = 0; j < COLS; j++) v[j*DW +: DW] = DW'(100 * r + j);
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] reduce(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        o = r;
`ifdef MOD_REDUCE_EN
        for (int j = 0; j < COLS; j++)
            if (r[j*DW +: DW] >= modulus) o[j*DW +: DW] = r[j*DW +: DW] - modulus;
`endif
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Reference model + scoreboard, evaluated mid-cycle
    // ------------------------------------------------------------------
    exp_t mon_hd;
    bit   mon_pop;
    bit   mon_full;
    int   mon_st0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", ROW_W'(out_valid), ROW_W'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_row", out_row, q[0].row);
                check("out_row_idx", ROW_W'(out_row_idx), ROW_W'(q[0].idx));
                check("out_last", ROW_W'(out_last), ROW_W'(q[0].idx == ROWS - 1));
            end else begin
                check("idle_out_row", out_row, '0);
                check("idle_out_idx_last", ROW_W'({out_row_idx, out_last}), '0);
            end
            check("busy", ROW_W'(busy), ROW_W'(m_st != M_IDLE));
            check("done", ROW_W'(done), ROW_W'(m_done));
            check("overflow", ROW_W'(overflow), ROW_W'(m_ovf));

            if (out_valid && out_ready) n_out++;
            if (done) n_done++;

            mon_full = (q.size() == DEPTH);
            mon_pop  = (q.size() != 0) && out_ready;
            mon_st0  = m_st;
            m_done   = 1'b0;
            if (srst) begin
                q.delete();
                m_st     = M_IDLE;
                m_ovf    = 1'b0;
                m_cnt_in = 0;
            end else begin
                if (mon_pop) mon_hd = q.pop_front();
                case (mon_st0)
                    M_IDLE: if (start) begin
                        m_st = M_COLLECT; m_cnt_in = 0; m_ovf = 1'b0;
                    end
                    M_COLLECT: if (in_valid) begin
                        if (!mon_full || mon_pop) q.push_back('{reduce(in_row), m_cnt_in});
                        else m_ovf = 1'b1;
                        if (m_cnt_in == ROWS - 1) m_st = M_DRAIN;
                        m_cnt_in++;
                    end
                    M_DRAIN: if (mon_pop && mon_hd.idx == ROWS - 1) begin
                        m_st = M_IDLE; m_done = 1'b1;
                    end
                    default: m_st = M_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic run_tile(input vec_t v);
        int out0, done0;
        out0  = n_out;
        done0 = n_done;
        if (v.idle_valid) begin
            in_valid = 1'b1; in_row = make_row(77);
            tick();
            in_valid = 1'b0;
            check("idle_ignored_valid", ROW_W'(out_valid), '0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = (v.ready_low_rows == 0);
        for (int r = 0; r < ROWS; r++) begin
            in_valid = 1'b1;
            in_row   = make_row(r);
            start    = v.second_start && (r == 2);
            if (r == v.ready_low_rows) out_ready = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (n_done > done0) break;
            tick();
        end
        tick();
        check("tile_rows", ROW_W'(n_out - out0), ROW_W'(v.exp_rows));
        check("tile_done", ROW_W'(n_done - done0), ROW_W'(v.exp_done));
        check("tile_overflow", ROW_W'(overflow), ROW_W'(v.exp_ovf));
        check("tile_busy_end", ROW_W'(busy), ROW_W'(v.exp_done == 0));
        if (v.exp_done == 0) begin
            pulse_reset();
            tick();
            check("post_srst_busy", ROW_W'(busy), '0);
        end
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{0,  1'b0, 1'b0, 10, 1, 1'b0};  // basic tile
        tbl[1] = '{4,  1'b0, 1'b0, 10, 1, 1'b0};  // back-pressure
        tbl[2] = '{10, 1'b0, 1'b0, 4,  0, 1'b1};  // overflow
        tbl[3] = '{0,  1'b1, 1'b1, 10, 1, 1'b0};  // ignored inputs

        srst = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0;
        modulus = 32'd17; out_ready = 1'b0;
        tick();
        tick();
        srst = 1'b0;
        check("reset_out_valid", ROW_W'(out_valid), '0);
        check("reset_out_row", out_row, '0);
        check("reset_flags", ROW_W'({busy, done, overflow, out_last}), '0);

        for (int k = 0; k < 4; k++) run_tile(tbl[k]);

        // Reset in the middle of a tile discards buffered rows.
        start = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1; in_row = make_row(r + 40);
            tick();
        end
        in_valid = 1'b0;
        check("midtile_valid_before", ROW_W'(out_valid), ROW_W'(1));
        pulse_reset();
        check("midtile_out_valid", ROW_W'(out_valid), '0);
        check("midtile_busy", ROW_W'(busy), '0);
        run_tile(tbl[0]);

`ifdef MOD_REDUCE_EN
        begin
            logic [ROW_W-1:0] r0;
            r0 = '0;
            r0[0 +: DW] = 32'd16; r0[DW +: DW] = 32'd17; r0[2*DW +: DW] = 32'd30;
            out_ready = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            in_valid = 1'b1; in_row = r0;
            tick();
            in_valid = 1'b0;
            check("mod_w0", ROW_W'(out_row[0 +: DW]), ROW_W'(16));
            check("mod_w1", ROW_W'(out_row[DW +: DW]), ROW_W'(0));
            check("mod_w2", ROW_W'(out_row[2*DW +: DW]), ROW_W'(13));
            out_ready = 1'b1;
            for (int r = 1; r < ROWS; r++) begin
                in_valid = 1'b1; in_row = make_row(r);
                tick();
            end
            in_valid = 1'b0;
            for (int i = 0; i < 20; i++) tick();
            check("mod_busy_end", ROW_W'(busy), '0);
        end
`endif

        tick();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
